uart_rx_line: RTL and testbench

UART 8N1 receiver for the multimeter's host link. It deserialises bytes from the PC terminal and assembles them into a fixed-width character array, using the same `CHAR_NR*8` packing as the transmit side. It publishes a complete line on CR/LF or when the array fills, so that the command parser can consume whole host commands. It sits between the board's RXD pin and the control logic, mirroring the UART transmit path.

---
 rtl/uart_rx_line.sv | 196 +++++++++++++++++++
 tb/tb_uart_rx_line.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_line.sv
// UART 8N1 receiver that assembles received bytes into a fixed-width line of characters.
// Latency: a line is published one clock after the stop-bit sample of its last byte.
// No backpressure: a published line holds until the next publish, clear or reset.
module uart_rx_line #(
  parameter int CHAR_NR     = 8,
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD        = 115200
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rxd_i,
  input  logic                 clr_i,
  output logic [CHAR_NR*8-1:0] char_array_o,
  output logic                 char_array_update_o,
  output logic                 frame_err_o,
  output logic                 busy_o
);

  localparam int BIT_CNT = (CLK_FREQ_HZ + BAUD / 2) / BAUD;
  localparam int CNT_W   = $clog2(BIT_CNT);
  localparam int WC_W    = (CHAR_NR > 1) ? $clog2(CHAR_NR) : 1;
  localparam int LW      = CHAR_NR * 8;
  localparam logic [LW-1:0] BLANK = {CHAR_NR{8'h20}};

  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;

  logic          rxd_s1_q, rxd_s2_q, rxd_s3_q;
  logic          rx_fall;

  state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          busy_q, busy_d;
  logic          upd_q, upd_d;
  logic          err_q, err_d;
  logic [LW-1:0] buf_q, buf_d;
  logic [WC_W-1:0] wcnt_q, wcnt_d;
  logic [LW-1:0] arr_q, arr_d;
  logic [LW-1:0] line_tmp;
  logic          byte_vld;

  // Two-stage synchroniser on the raw line plus one stage for falling-edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_s1_q <= 1'b1;
      rxd_s2_q <= 1'b1;
      rxd_s3_q <= 1'b1;
    end else begin
      rxd_s1_q <= rxd_i;
      rxd_s2_q <= rxd_s1_q;
      rxd_s3_q <= rxd_s2_q;
    end
  end

  assign rx_fall = rxd_s3_q & ~rxd_s2_q;

  // Frame FSM next state, then line assembly of completed bytes; clear overrides all.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    busy_d   = busy_q;
    upd_d    = 1'b0;
    err_d    = 1'b0;
    buf_d    = buf_q;
    wcnt_d   = wcnt_q;
    arr_d    = arr_q;
    byte_vld = 1'b0;
    line_tmp = buf_q;

    case (state_q)
      S_IDLE: begin
        if (rx_fall) begin
          state_d = S_START;
          cnt_d   = CNT_W'(BIT_CNT / 2 - 1);
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          if (!rxd_s2_q) begin
            state_d = S_DATA;
            cnt_d   = CNT_W'(BIT_CNT - 1);
            idx_d   = 3'd0;
            busy_d  = 1'b1;
          end else begin
            // Start bit did not hold low: a glitch, drop it silently.
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          shift_d[idx_q] = rxd_s2_q;
          cnt_d          = CNT_W'(BIT_CNT - 1);
          if (idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_STOP: begin
        if (cnt_q == '0) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          if (rxd_s2_q) begin
            byte_vld = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (byte_vld) begin
      if (shift_q == 8'h0D || shift_q == 8'h0A) begin
        // Terminator on an empty line is ignored so CR LF yields one line.
        if (wcnt_q != '0) begin
          arr_d  = buf_q;
          upd_d  = 1'b1;
          buf_d  = BLANK;
          wcnt_d = '0;
        end
      end else begin
        for (int i = 0; i < CHAR_NR; i++) begin
          if (wcnt_q == WC_W'(i)) begin
            line_tmp[(CHAR_NR-1-i)*8 +: 8] = shift_q;
          end
        end
        if (wcnt_q == WC_W'(CHAR_NR - 1)) begin
          arr_d  = line_tmp;
          upd_d  = 1'b1;
          buf_d  = BLANK;
          wcnt_d = '0;
        end else begin
          buf_d  = line_tmp;
          wcnt_d = wcnt_q + WC_W'(1);
        end
      end
    end

    if (clr_i) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      idx_d   = 3'd0;
      busy_d  = 1'b0;
      upd_d   = 1'b0;
      err_d   = 1'b0;
      buf_d   = BLANK;
      wcnt_d  = '0;
      arr_d   = BLANK;
    end
  end

  // All FSM, line and output state registered together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      busy_q  <= 1'b0;
      upd_q   <= 1'b0;
      err_q   <= 1'b0;
      buf_q   <= BLANK;
      wcnt_q  <= '0;
      arr_q   <= BLANK;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      busy_q  <= busy_d;
      upd_q   <= upd_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
      wcnt_q  <= wcnt_d;
      arr_q   <= arr_d;
    end
  end

  assign char_array_o        = arr_q;
  assign char_array_update_o = upd_q;
  assign frame_err_o         = err_q;
  assign busy_o              = busy_q;

endmodule

// File: tb/tb_uart_rx_line.sv
// Testbench for uart_rx_line: serial stimulus with a scoreboard of expected lines.
// Lines are popped and compared on every update pulse; error pulses are counted.
// Timing: inputs change 1 time unit after posedge, outputs sampled on negedge.
module tb_uart_rx_line;

  localparam int CHAR_NR = 4;
  localparam int BITC    = 10;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rxd = 1'b1;
  logic        clr = 1'b0;
  logic [31:0] arr;
  logic        upd, err, busy;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];
  int  err_seen = 0;
  int  err_exp  = 0;
  logic busy_seen = 1'b0;
  logic upd_prev = 1'b0;
  logic err_prev = 1'b0;

  uart_rx_line #(
    .CHAR_NR    (CHAR_NR),
    .CLK_FREQ_HZ(1_000_000),
    .BAUD       (100_000)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .rxd_i              (rxd),
    .clr_i              (clr),
    .char_array_o       (arr),
    .char_array_update_o(upd),
    .frame_err_o        (err),
    .busy_o             (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard / pulse monitor
  always @(negedge clk) begin
    if (upd) begin
      check("upd_width", {31'b0, upd_prev}, 32'd0);
      if (exp_q.size() > 0) check("line", arr, exp_q.pop_front());
      else                  check("upd_unexpected", {31'b0, upd}, 32'd0);
    end
    if (err) begin
      err_seen++;
      check("err_width", {31'b0, err_prev}, 32'd0);
    end
    if (busy) busy_seen = 1'b1;
    upd_prev = upd;
    err_prev = err;
  end

  task automatic drive_bit(input logic v);
    rxd = v;
    repeat (BITC) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit = 1'b1, input int gap = BITC);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop_bit);
    rxd = 1'b1;
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset state
    idle(3);
    check("rst_arr", arr, 32'h20202020);
    check("rst_upd", {31'b0, upd}, 32'd0);
    check("rst_err", {31'b0, err}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    idle(5);

    // Line with CR terminator
    exp_q.push_back(32'h41422020);
    send_str("AB");
    send_byte(8'h0D);

    // CR LF gives one line
    exp_q.push_back(32'h31322020);
    send_str("12");
    send_byte(8'h0D);
    send_byte(8'h0A);

    // Full array publishes on the last slot; trailing CR ignored
    exp_q.push_back(32'h5758595A);
    send_str("WXYZ");
    send_byte(8'h0D);
    check("hold_arr", arr, 32'h5758595A);

    // Framing error discards the byte
    err_exp++;
    send_byte(8'h55, 1'b0);
    exp_q.push_back(32'h51202020);
    send_str("Q");
    send_byte(8'h0A);
    check("err_cnt_fe", err_seen, err_exp);

    // Break: one error, no restart while low
    err_exp++;
    rxd = 1'b0;
    idle(12 * BITC);
    rxd = 1'b1;
    idle(3 * BITC);
    check("err_cnt_brk", err_seen, err_exp);

    // Glitch: 3-clock low pulse
    busy_seen = 1'b0;
    rxd = 1'b0;
    idle(3);
    rxd = 1'b1;
    idle(3 * BITC);
    check("glitch_busy", {31'b0, busy_seen}, 32'd0);

    // Abort mid-frame with clr
    send_str("AB");
    drive_bit(1'b0);
    drive_bit(1'b1);
    rxd = 1'b1;
    idle(BITC / 2);
    check("pre_clr_busy", {31'b0, busy}, 32'd1);
    clr = 1'b1;
    idle(1);
    clr = 1'b0;
    check("clr_busy", {31'b0, busy}, 32'd0);
    check("clr_arr", arr, 32'h20202020);
    idle(2 * BITC * 10);
    exp_q.push_back(32'h44202020);
    send_str("D");
    send_byte(8'h0D);

    // Async reset mid-frame
    drive_bit(1'b0);
    drive_bit(1'b0);
    check("pre_rst_busy", {31'b0, busy}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    check("mid_rst_arr", arr, 32'h20202020);
    check("mid_rst_busy", {31'b0, busy}, 32'd0);
    check("mid_rst_upd", {31'b0, upd}, 32'd0);
    rxd = 1'b1;
    idle(4);
    rst = 1'b0;
    idle(5);
    exp_q.push_back(32'h45202020);
    send_str("E");
    send_byte(8'h0D);

    // Back-to-back frames, no idle gap
    exp_q.push_back(32'h61622020);
    send_byte(8'h61, 1'b1, 0);
    send_byte(8'h62, 1'b1, 0);
    send_byte(8'h0D);

    idle(50);
    check("queue_empty", exp_q.size(), 32'd0);
    check("err_total", err_seen, err_exp);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
